// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, owner IDs,
// slave-select decode and parameter defaults.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_CONNECT = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT       = 16;
    localparam int ADDR_SEL_BITS_DEFAULT = 2;

    localparam logic OWNER_M1 = 1'b0;
    localparam logic OWNER_M2 = 1'b1;

    localparam logic [1:0] ADDR_INVALID = 2'd3;
    localparam logic [2:0] SEL_NONE     = 3'b000;

    function automatic logic [2:0] decode_slave(input logic [1:0] addr);
        case (addr)
            2'd0:    decode_slave = 3'b001;
            2'd1:    decode_slave = 3'b010;
            2'd2:    decode_slave = 3'b100;
            default: decode_slave = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the master that did not own the
// previous transaction wins.
module rr_arbiter2
    import bus_pkg::*;
(
    input  logic i_req1,
    input  logic i_req2,
    input  logic i_last_owner,
    output logic o_sel
);

    always_comb begin
        o_sel = OWNER_M1;
        if (i_req1 && i_req2) begin
            o_sel = ~i_last_owner;
        end else if (i_req2) begin
            o_sel = OWNER_M2;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin grant, serial 2-bit slave address
// capture, per-slave ready timeout and one-cycle release gap.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT       = TIMEOUT_DEFAULT,
    parameter int ADDR_SEL_BITS = ADDR_SEL_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_valid,
    input  logic       m2_valid,
    input  logic       m1_tx_address,
    input  logic       m2_tx_address,
    input  logic       m1_done,
    input  logic       m2_done,
    input  logic [2:0] slave_ready,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic [2:0] slave_sel,
    output logic       bus_owner,
    output logic       bus_error
);

    state_t                   r_state;
    logic                     r_m1_grant;
    logic                     r_m2_grant;
    logic [2:0]               r_slave_sel;
    logic                     r_bus_owner;
    logic                     r_bus_error;
    logic                     r_last_owner;
    logic [ADDR_SEL_BITS-2:0] r_shift;
    logic [1:0]               r_bit_cnt;
    logic [4:0]               r_wait_cnt;

    state_t                   w_state_nxt;
    logic                     w_m1_grant_nxt;
    logic                     w_m2_grant_nxt;
    logic [2:0]               w_slave_sel_nxt;
    logic                     w_bus_owner_nxt;
    logic                     w_bus_error_nxt;
    logic                     w_last_owner_nxt;
    logic [ADDR_SEL_BITS-2:0] w_shift_nxt;
    logic [1:0]               w_bit_cnt_nxt;
    logic [4:0]               w_wait_cnt_nxt;
    logic                     w_release;

    logic                     w_rr_sel;
    logic                     w_own_req;
    logic                     w_own_valid;
    logic                     w_own_addr;
    logic                     w_own_done;
    logic                     w_own_ready;
    logic [ADDR_SEL_BITS-1:0] w_addr_full;

    rr_arbiter2 u_rr (
        .i_req1       (m1_req),
        .i_req2       (m2_req),
        .i_last_owner (r_last_owner),
        .o_sel        (w_rr_sel)
    );

    // Only the current owner's handshake is looked at; the other master is ignored.
    assign w_own_req   = r_bus_owner ? m2_req        : m1_req;
    assign w_own_valid = r_bus_owner ? m2_valid      : m1_valid;
    assign w_own_addr  = r_bus_owner ? m2_tx_address : m1_tx_address;
    assign w_own_done  = r_bus_owner ? m2_done       : m1_done;
    assign w_own_ready = |(slave_ready & r_slave_sel);
    assign w_addr_full = {r_shift, w_own_addr};

    always_comb begin
        w_state_nxt      = r_state;
        w_m1_grant_nxt   = r_m1_grant;
        w_m2_grant_nxt   = r_m2_grant;
        w_slave_sel_nxt  = r_slave_sel;
        w_bus_owner_nxt  = r_bus_owner;
        w_bus_error_nxt  = 1'b0;
        w_last_owner_nxt = r_last_owner;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_release        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (m1_req || m2_req) begin
                    w_state_nxt     = ST_ADDR;
                    w_bus_owner_nxt = w_rr_sel;
                    w_m1_grant_nxt  = (w_rr_sel == OWNER_M1);
                    w_m2_grant_nxt  = (w_rr_sel == OWNER_M2);
                    w_shift_nxt     = '0;
                    w_bit_cnt_nxt   = '0;
                    w_wait_cnt_nxt  = '0;
                end
            end
            ST_ADDR: begin
                if (!w_own_req) begin
                    w_release = 1'b1;
                end else if (w_own_valid) begin
                    w_shift_nxt = w_addr_full[ADDR_SEL_BITS-2:0];
                    if (r_bit_cnt == 2'(ADDR_SEL_BITS - 1)) begin
                        if (w_addr_full == ADDR_INVALID) begin
                            w_bus_error_nxt = 1'b1;
                            w_release       = 1'b1;
                        end else begin
                            w_slave_sel_nxt = decode_slave(w_addr_full);
                            w_wait_cnt_nxt  = '0;
                            w_state_nxt     = ST_CONNECT;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 2'd1;
                    end
                end
            end
            ST_CONNECT: begin
                // Abort and done both beat the timeout, so neither raises an error.
                if (!w_own_req || w_own_done) begin
                    w_release = 1'b1;
                end else if (w_own_ready) begin
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == 5'(TIMEOUT - 1)) begin
                    w_bus_error_nxt = 1'b1;
                    w_release       = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_release) begin
            w_state_nxt      = ST_RELEASE;
            w_m1_grant_nxt   = 1'b0;
            w_m2_grant_nxt   = 1'b0;
            w_slave_sel_nxt  = SEL_NONE;
            w_last_owner_nxt = r_bus_owner;
        end
    end

    // r_last_owner resets to master 2 so that master 1 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_m1_grant   <= 1'b0;
            r_m2_grant   <= 1'b0;
            r_slave_sel  <= SEL_NONE;
            r_bus_owner  <= OWNER_M1;
            r_bus_error  <= 1'b0;
            r_last_owner <= OWNER_M2;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_m1_grant   <= w_m1_grant_nxt;
            r_m2_grant   <= w_m2_grant_nxt;
            r_slave_sel  <= w_slave_sel_nxt;
            r_bus_owner  <= w_bus_owner_nxt;
            r_bus_error  <= w_bus_error_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
        end
    end

    assign m1_grant  = r_m1_grant;
    assign m2_grant  = r_m2_grant;
    assign slave_sel = r_slave_sel;
    assign bus_owner = r_bus_owner;
    assign bus_error = r_bus_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_req, m2_req, m1_valid, m2_valid;
    logic       m1_tx_address, m2_tx_address, m1_done, m2_done;
    logic [2:0] slave_ready;
    logic       m1_grant, m2_grant, bus_owner, bus_error;
    logic [2:0] slave_sel;

    int total = 0;
    int bad   = 0;
    bit m_last = 1'b1;  // 1: master 2 owned last, so master 1 wins a tie

    bus_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_SEL_BITS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .m1_req        (m1_req),
        .m2_req        (m2_req),
        .m1_valid      (m1_valid),
        .m2_valid      (m2_valid),
        .m1_tx_address (m1_tx_address),
        .m2_tx_address (m2_tx_address),
        .m1_done       (m1_done),
        .m2_done       (m2_done),
        .slave_ready   (slave_ready),
        .m1_grant      (m1_grant),
        .m2_grant      (m2_grant),
        .slave_sel     (slave_sel),
        .bus_owner     (bus_owner),
        .bus_error     (bus_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m1_req = 0; m2_req = 0; m1_valid = 0; m2_valid = 0;
        m1_tx_address = 0; m2_tx_address = 0; m1_done = 0; m2_done = 0;
        slave_ready = 3'b000;
    endtask

    // One complete transaction with the winning master chosen by the model.
    task automatic run_txn(input bit r1, input bit r2, input logic [1:0] addr,
                           input bit gaps, input int rmode, input int done_after,
                           input int abort_at);
        bit win;
        int idx = 0, cyc = 0, conn_k = 0, run = 0;
        bit in_conn = 0, fin = 0, ab, v = 0, rdy = 0, dn = 0;
        logic [2:0] esel = 3'b000;
        logic [5:0] obs, exp;
        win = (r1 && r2) ? !m_last : r2;
        m1_req = r1; m2_req = r2;
        step();
        total++;
        obs = {m1_grant, m2_grant, slave_sel, bus_error};
        exp = {!win, win, 3'b000, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL txn_grant got=%b exp=%b", obs, exp); end
        total++;
        if (bus_owner !== win) begin bad++; $display("FAIL txn_owner got=%b exp=%b", bus_owner, win); end
        while (!fin) begin
            cyc++;
            if (cyc > 200) begin
                total++; bad++;
                $display("FAIL txn_bound got=%0d cycles exp=<=200", cyc);
                break;
            end
            if (win) begin
                m1_valid = 1'($urandom_range(0, 1)); m1_tx_address = 1'($urandom_range(0, 1));
                m1_done = 1'($urandom_range(0, 1));
            end else begin
                m2_valid = 1'($urandom_range(0, 1)); m2_tx_address = 1'($urandom_range(0, 1));
                m2_done = 1'($urandom_range(0, 1));
            end
            slave_ready = 3'($urandom_range(0, 7));
            ab = (abort_at == cyc);
            if (ab) begin
                if (win) m2_req = 0; else m1_req = 0;
            end
            if (!in_conn) begin
                v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (win) begin
                    m2_valid = v; m2_done = 0;
                    m2_tx_address = v ? addr[1-idx] : 1'($urandom_range(0, 1));
                end else begin
                    m1_valid = v; m1_done = 0;
                    m1_tx_address = v ? addr[1-idx] : 1'($urandom_range(0, 1));
                end
            end else begin
                conn_k++;
                dn  = (conn_k == done_after);
                rdy = (rmode == 1) || (rmode == 2 && $urandom_range(0, 3) == 0);
                if (win) m2_done = dn; else m1_done = dn;
                slave_ready = rdy ? (slave_ready | esel) : (slave_ready & ~esel);
            end
            step();
            if (ab) begin
                exp = 6'b000000; fin = 1;
            end else if (!in_conn) begin
                if (v) idx++;
                if (idx == 2) begin
                    if (addr == 2'd3) begin
                        exp = 6'b000001; fin = 1;
                    end else begin
                        esel = 3'b001 << addr; in_conn = 1;
                        exp = {!win, win, esel, 1'b0};
                    end
                end else begin
                    exp = {!win, win, 3'b000, 1'b0};
                end
            end else if (dn) begin
                exp = 6'b000000; fin = 1;
            end else begin
                run = rdy ? 0 : run + 1;
                if (run == TIMEOUT) begin
                    exp = 6'b000001; fin = 1;
                end else begin
                    exp = {!win, win, esel, 1'b0};
                end
            end
            total++;
            obs = {m1_grant, m2_grant, slave_sel, bus_error};
            if (obs !== exp) begin
                bad++;
                $display("FAIL txn_cycle%0d got=%b exp=%b (grants,sel,err)", cyc, obs, exp);
            end
        end
        clear_inputs();
        step();
        total++;
        obs = {m1_grant, m2_grant, slave_sel, bus_error};
        if (obs !== 6'b000000) begin bad++; $display("FAIL txn_release got=%b exp=000000", obs); end
        m_last = win;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        reset = 0; m1_req = 1; m2_req = 1; m1_valid = 1; m1_done = 1; slave_ready = 3'b111;
        step(); step();
        total++;
        obs = {m1_grant, m2_grant, slave_sel, bus_owner, bus_error};
        if (obs !== 7'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=0000000", obs); end
        clear_inputs();
        reset = 1;
        m_last = 1'b1;
        step();
    endtask

    task automatic test_single();
        run_txn(1, 0, 2'b01, 0, 1, 5, 0);
    endtask

    task automatic test_round_robin();
        reset = 0; step(); reset = 1; m_last = 1'b1;
        m1_req = 1; m2_req = 1;
        step();
        total++;
        if ({m1_grant, m2_grant, bus_owner} !== 3'b100) begin
            bad++; $display("FAIL rr_first got=%b exp=100", {m1_grant, m2_grant, bus_owner});
        end
        m1_valid = 1; m1_tx_address = 0;
        step(); step();
        total++;
        if (slave_sel !== 3'b001) begin bad++; $display("FAIL rr_sel1 got=%b exp=001", slave_sel); end
        slave_ready = 3'b001; m1_done = 1;
        step();
        total++;
        if ({m1_grant, m2_grant} !== 2'b00) begin bad++; $display("FAIL rr_rel1 got=%b exp=00", {m1_grant, m2_grant}); end
        m1_done = 0; m1_valid = 0;
        step();
        total++;
        if ({m1_grant, m2_grant} !== 2'b00) begin bad++; $display("FAIL rr_gap got=%b exp=00", {m1_grant, m2_grant}); end
        step();
        total++;
        if ({m1_grant, m2_grant, bus_owner} !== 3'b011) begin
            bad++; $display("FAIL rr_second got=%b exp=011", {m1_grant, m2_grant, bus_owner});
        end
        m2_valid = 1; m2_tx_address = 1;
        step();
        m2_tx_address = 0;
        step();
        total++;
        if (slave_sel !== 3'b100) begin bad++; $display("FAIL rr_sel2 got=%b exp=100", slave_sel); end
        m2_done = 1;
        step();
        m2_done = 0; m2_req = 0; m2_valid = 0;
        step(); step();
        total++;
        if ({m1_grant, m2_grant, bus_owner} !== 3'b100) begin
            bad++; $display("FAIL rr_third got=%b exp=100", {m1_grant, m2_grant, bus_owner});
        end
        m1_req = 0;
        step();
        clear_inputs();
        step();
        m_last = 1'b0;
    endtask

    task automatic test_bad_addr();
        run_txn(0, 1, 2'b11, 0, 1, 0, 0);
        run_txn(1, 1, 2'b11, 1, 1, 0, 0);
    endtask

    task automatic test_timeout();
        run_txn(1, 0, 2'b00, 0, 0, 0, 0);
        run_txn(1, 0, 2'b00, 0, 0, 16, 0);
        run_txn(0, 1, 2'b10, 0, 0, 17, 0);
    endtask

    task automatic test_valid_gaps();
        m1_req = 1;
        step();
        total++;
        if (m1_grant !== 1'b1) begin bad++; $display("FAIL gap_grant got=%b exp=1", m1_grant); end
        m1_valid = 1; m1_tx_address = 1;
        step();
        m1_valid = 0; m1_tx_address = 1;
        step();
        total++;
        if ({slave_sel, bus_error, m1_grant} !== 5'b00001) begin
            bad++; $display("FAIL gap_skip got=%b exp=00001", {slave_sel, bus_error, m1_grant});
        end
        m1_valid = 1; m1_tx_address = 0;
        step();
        total++;
        if (slave_sel !== 3'b100) begin bad++; $display("FAIL gap_decode got=%b exp=100", slave_sel); end
        m1_valid = 0; m1_done = 1;
        step();
        clear_inputs();
        step();
        m_last = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs;
        run_txn(1, 0, 2'b10, 0, 1, 3, 0);
        m1_req = 1;
        step();
        m1_valid = 1; m1_tx_address = 0;
        step();
        m1_tx_address = 1;
        step();
        total++;
        if (slave_sel !== 3'b010) begin bad++; $display("FAIL mid_connect got=%b exp=010", slave_sel); end
        m1_valid = 0; m2_req = 1; reset = 0;
        step();
        total++;
        obs = {m1_grant, m2_grant, slave_sel, bus_owner, bus_error};
        if (obs !== 7'b0) begin bad++; $display("FAIL mid_reset got=%b exp=0000000", obs); end
        reset = 1;
        m_last = 1'b1;
        step();
        total++;
        if ({m1_grant, m2_grant} !== 2'b10) begin bad++; $display("FAIL mid_prio got=%b exp=10", {m1_grant, m2_grant}); end
        m1_req = 0; m2_req = 0;
        step();
        clear_inputs();
        step();
        m_last = 1'b0;
    endtask

    task automatic test_random();
        int rs, rm, da, ab;
        for (int i = 0; i < 40; i++) begin
            rs = $urandom_range(1, 3);
            rm = $urandom_range(0, 2);
            da = (rm == 0) ? $urandom_range(0, 20) : $urandom_range(1, 20);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
            run_txn(rs[0], rs[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rm, da, ab);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_bad_addr();
        test_timeout();
        test_valid_gaps();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum CONNECT cycles allowed with the selected slave not ready.
REQ-002 Parameter ADDR_SEL_BITS, default 2: number of address MSBs decoded for slave select; fixed at 2 in this revision.
REQ-003 clk  in  1  system clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 m1_req, m2_req  in  1 each  master bus request; held for the whole transaction.
REQ-006 m1_valid, m2_valid  in  1 each  master serial bit valid.
REQ-007 m1_tx_address, m2_tx_address  in  1 each  master serial address bit, MSB first.
REQ-008 m1_done, m2_done  in  1 each  single-cycle transaction-complete pulse.
REQ-009 slave_ready  in  3  per-slave ready.
REQ-010 m1_grant, m2_grant  out  1 each  bus grant; one-hot or zero.
REQ-011 slave_sel  out  3  one-hot slave select; zero when unassigned.
REQ-012 bus_owner  out  1  0 = master 1, 1 = master 2; valid while a grant is high.
REQ-013 bus_error  out  1  single-cycle error pulse.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have four states: IDLE, ADDR, CONNECT, RELEASE.
REQ-016 In IDLE with any req high, the arbiter SHALL assert the chosen grant on the next edge and enter ADDR.
REQ-017 Arbitration SHALL be round-robin: the master that did not own the last transaction wins a simultaneous request; master 1 SHALL have priority after reset.
REQ-018 In ADDR, the arbiter SHALL shift in the owner's tx_address only on cycles where the owner's valid is 1; bits with valid=0 SHALL NOT be captured.
REQ-019 After two captured bits, on the same edge, the arbiter SHALL act on the decoded value: 0/1/2 sets slave_sel to the matching one-hot bit and enters CONNECT; 3 pulses bus_error and enters RELEASE.
REQ-020 In CONNECT, a 5-bit counter SHALL increment each cycle slave_ready[sel] is 0 and clear when it is 1.
REQ-021 When the counter reaches TIMEOUT-1 with the slave still not ready, the arbiter SHALL pulse bus_error and enter RELEASE.
REQ-022 In CONNECT, the owner's done=1 SHALL cause entry to RELEASE; if done coincides with the timeout, done SHALL win and bus_error SHALL stay 0.
REQ-023 If the owner's req drops in ADDR or CONNECT, the transaction SHALL abort: enter RELEASE with no error.
REQ-024 On entering RELEASE, grants and slave_sel SHALL clear and the last-owner flag SHALL update.
REQ-025 RELEASE SHALL last one cycle and then return to IDLE, so back-to-back transactions have a 1-cycle gap.
REQ-026 The non-owner's req, valid, tx_address and done SHALL be ignored while a grant is active.

Reset
REQ-027 With reset=0 at an edge: state=IDLE, grants=0, slave_sel=0, bus_owner=0, bus_error=0, counters and shift register=0, last-owner flag set so master 1 has priority.
REQ-028 Reset mid-transaction SHALL drop the grant on that edge with no bus_error.

Structure
REQ-029 State encodings, slave-select decode values and the TIMEOUT default SHALL live in shared package bus_pkg.
REQ-030 The round-robin priority logic SHALL be a sub-module rr_arbiter2 (inputs: two requests, last-owner flag; output: grant select).

Verification
REQ-031 m1_req only, address bits 0,1 (valid every cycle), slave_ready[1]=1, m1_done after 5 cycles -> m1_grant=1 one cycle after req; slave_sel=3'b010 after the second bit; grant clears on the edge after done.
REQ-032 m1_req and m2_req high together from reset -> m1 granted first; after m1_done, m2 granted two cycles later.
REQ-033 Address bits 1,1 -> bus_error high for exactly one cycle; slave_sel stays 0; grant released.
REQ-034 Address bits 0,0, slave_ready[0]=0 -> bus_error on the 16th CONNECT cycle; same test with done on that cycle -> no error.
REQ-035 valid toggling 1,0,1 during ADDR with tx_address 1,x,0 -> decode 2 (slave_sel=3'b100).
REQ-036 reset=0 asserted during CONNECT -> all outputs 0 on the next edge; the next request is served by master 1.
